// File: rtl/i2c_init_sequencer_pkg.sv
// Shared types and the default ST7565 power-up command table for the I2C
// init sequencer.
package i2c_init_pkg;

    localparam int ENTRY_DELAY_W = 8;
    localparam int DEFAULT_DEPTH = 10;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;
    localparam logic [7:0] CMD_NOP   = 8'hE3;

    typedef struct packed {
        logic [7:0]               reg_addr;
        logic [7:0]               tx_data;
        logic [ENTRY_DELAY_W-1:0] delay;
    } init_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DELAY = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_t;

    function automatic init_entry_t mk_cmd(input logic [7:0] data,
                                           input logic [ENTRY_DELAY_W-1:0] dly);
        init_entry_t e;
        e.reg_addr = CTRL_CMD;
        e.tx_data  = data;
        e.delay    = dly;
        return e;
    endfunction

    // Soft reset (E2) and power control (2F) need settling time before the next command.
    function automatic init_entry_t default_entry(input logic [7:0] idx);
        init_entry_t e;
        case (idx)
            8'd0:    e = mk_cmd(8'hE2, 8'd3);
            8'd1:    e = mk_cmd(8'hA2, 8'd0);
            8'd2:    e = mk_cmd(8'hA0, 8'd0);
            8'd3:    e = mk_cmd(8'hC8, 8'd0);
            8'd4:    e = mk_cmd(8'h25, 8'd0);
            8'd5:    e = mk_cmd(8'h81, 8'd0);
            8'd6:    e = mk_cmd(8'h20, 8'd0);
            8'd7:    e = mk_cmd(8'h2F, 8'd2);
            8'd8:    e = mk_cmd(8'hAF, 8'd0);
            8'd9:    e = mk_cmd(8'h40, 8'd0);
            default: e = mk_cmd(CMD_NOP, 8'd0);
        endcase
        return e;
    endfunction

endpackage

// File: rtl/i2c_init_sequencer_if.sv
// Write-command handshake between the init sequencer and the I2C master
// transmitter.
interface i2c_init_sequencer_if;

    logic [7:0] reg_addr;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_done;
    logic       tx_nack;

    modport master (
        output reg_addr,
        output tx_data,
        output tx_en,
        input  tx_done,
        input  tx_nack
    );

    modport slave (
        input  reg_addr,
        input  tx_data,
        input  tx_en,
        output tx_done,
        output tx_nack
    );

endinterface

// File: rtl/i2c_init_sequencer_rom.sv
// Read-only init table: DEPTH entries taken from the package default table,
// read combinationally by index.
module i2c_init_rom
    import i2c_init_pkg::*;
#(
    parameter int DEPTH   = 10,
    parameter int DELAY_W = 8,
    parameter int IDX_W   = 4
) (
    input  logic [IDX_W-1:0]   index_i,
    output logic [7:0]         reg_addr_o,
    output logic [7:0]         tx_data_o,
    output logic [DELAY_W-1:0] delay_o
);

    init_entry_t entry_s;

    // Table lookup; delay field resized to the configured delay width.
    always_comb begin
        entry_s    = default_entry(8'(index_i));
        reg_addr_o = entry_s.reg_addr;
        tx_data_o  = entry_s.tx_data;
        delay_o    = DELAY_W'(entry_s.delay);
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Table-driven I2C write sequencer: replays the init ROM through the master's
// tx_en/tx_done handshake with NACK retries and prescaled post-write delays.
module i2c_init_sequencer
    import i2c_init_pkg::*;
#(
    parameter int DEPTH      = 10,
    parameter int DELAY_W    = 8,
    parameter int PRESCALE   = 1000,
    parameter int MAX_RETRY  = 3,
    parameter int AUTO_START = 1,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    i2c_init_sequencer_if.master bus,
    output logic                 busy_o,
    output logic                 init_complete_o,
    output logic                 error_o,
    output logic [IDX_W-1:0]     err_index_o
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   err_index_q, err_index_d;
    logic               tx_en_q, tx_en_d;
    logic               busy_q, busy_d;
    logic               init_q, init_d;
    logic               error_q, error_d;

    seq_state_t         adv_state_s;
    logic [IDX_W-1:0]   adv_index_s;
    logic [7:0]         rom_addr_s;
    logic [7:0]         rom_data_s;
    logic [DELAY_W-1:0] rom_delay_s;

    i2c_init_rom #(
        .DEPTH   (DEPTH),
        .DELAY_W (DELAY_W),
        .IDX_W   (IDX_W)
    ) u_rom (
        .index_i    (index_q),
        .reg_addr_o (rom_addr_s),
        .tx_data_o  (rom_data_s),
        .delay_o    (rom_delay_s)
    );

    // Where the sequence goes once the current entry (and its delay) is finished.
    always_comb begin
        if (index_q == IDX_W'(DEPTH - 1)) begin
            adv_state_s = ST_DONE;
            adv_index_s = index_q;
        end else begin
            adv_state_s = ST_ISSUE;
            adv_index_s = index_q + IDX_W'(1);
        end
    end

    // Next-state logic; status outputs are registered copies decoded from state_d.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        delay_d     = delay_q;
        presc_d     = presc_q;
        err_index_d = err_index_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    index_d = '0;
                    retry_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ISSUE: begin
                // Right after reset the pulse has not been driven yet; hold one cycle to emit it.
                if (tx_en_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.tx_done) begin
                    if (bus.tx_nack) begin
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ST_ISSUE;
                        end else begin
                            err_index_d = index_q;
                            state_d     = ST_ERROR;
                        end
                    end else begin
                        retry_d = '0;
                        if (rom_delay_s == '0) begin
                            state_d = adv_state_s;
                            index_d = adv_index_s;
                        end else begin
                            delay_d = rom_delay_s;
                            presc_d = '0;
                            state_d = ST_DELAY;
                        end
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DELAY: begin
                if (presc_q == PRE_W'(PRESCALE - 1)) begin
                    presc_d = '0;
                    delay_d = delay_q - DELAY_W'(1);
                    if (delay_q == DELAY_W'(1)) begin
                        state_d = adv_state_s;
                        index_d = adv_index_s;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_en_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_DELAY);
        init_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= (AUTO_START != 0) ? ST_ISSUE : ST_IDLE;
            index_q     <= '0;
            retry_q     <= '0;
            delay_q     <= '0;
            presc_q     <= '0;
            err_index_q <= '0;
            tx_en_q     <= 1'b0;
            busy_q      <= (AUTO_START != 0) ? 1'b1 : 1'b0;
            init_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            delay_q     <= delay_d;
            presc_q     <= presc_d;
            err_index_q <= err_index_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            init_q      <= init_d;
            error_q     <= error_d;
        end
    end

    assign bus.reg_addr    = rom_addr_s;
    assign bus.tx_data     = rom_data_s;
    assign bus.tx_en       = tx_en_q;
    assign busy_o          = busy_q;
    assign init_complete_o = init_q;
    assign error_o         = error_q;
    assign err_index_o     = err_index_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench: instance A (auto-start, PRESCALE=4) covers the full sequence,
// retries, error and restart; instance B (manual start) covers async reset.
module tb_i2c_init_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, start_a, start_b;
    logic       busy_a, init_a, err_a, busy_b, init_b, err_b;
    logic [3:0] eidx_a, eidx_b;

    i2c_init_sequencer_if ifa ();
    i2c_init_sequencer_if ifb ();

    i2c_init_sequencer #(
        .DEPTH(10), .DELAY_W(8), .PRESCALE(4), .MAX_RETRY(3), .AUTO_START(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start_i(start_a), .bus(ifa),
        .busy_o(busy_a), .init_complete_o(init_a), .error_o(err_a), .err_index_o(eidx_a)
    );

    i2c_init_sequencer #(
        .DEPTH(10), .DELAY_W(8), .PRESCALE(2), .MAX_RETRY(3), .AUTO_START(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start_i(start_b), .bus(ifb),
        .busy_o(busy_b), .init_complete_o(init_b), .error_o(err_b), .err_index_o(eidx_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_tbl [10] = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'h25,
                                 8'h81, 8'h20, 8'h2F, 8'hAF, 8'h40};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Wait for a tx_en pulse on A, check its shape, then acknowledge (or NACK).
    task automatic serve_a(input logic nack, input logic poke, output logic [7:0] data,
                           output int gap);
        gap = 0;
        while (ifa.tx_en !== 1'b1 && gap < 100) begin
            @(posedge clk); #1; gap++;
        end
        check("a_tx_en_seen", 32'(ifa.tx_en), 32'd1);
        check("a_reg_addr", 32'(ifa.reg_addr), 32'h00);
        data = ifa.tx_data;
        @(posedge clk); #1;
        check("a_tx_en_width", 32'(ifa.tx_en), 32'd0);
        if (poke) begin
            start_a = 1'b1; ifa.tx_nack = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0; ifa.tx_nack = 1'b0;
        end
        ifa.tx_done = 1'b1; ifa.tx_nack = nack;
        @(posedge clk); #1;
        ifa.tx_done = 1'b0; ifa.tx_nack = 1'b0;
    endtask

    task automatic serve_b(input logic respond, output logic [7:0] data);
        int n = 0;
        while (ifb.tx_en !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("b_tx_en_seen", 32'(ifb.tx_en), 32'd1);
        data = ifb.tx_data;
        @(posedge clk); #1;
        if (respond) begin
            ifb.tx_done = 1'b1;
            @(posedge clk); #1;
            ifb.tx_done = 1'b0;
        end
    endtask

    task automatic count_a_pulses(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ifa.tx_en === 1'b1) cnt++;
        end
    endtask

    task automatic count_b_pulses(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ifb.tx_en === 1'b1) cnt++;
        end
    endtask

    logic [7:0] t2_data [12] = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'hC8, 8'hC8,
                                 8'h25, 8'h81, 8'h20, 8'h2F, 8'hAF, 8'h40};
    logic       t2_nack [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] t3_data [9]  = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'h25,
                                 8'h81, 8'h81, 8'h81, 8'h81};
    logic       t3_nack [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [7:0] d;
        int         gap;
        int         cnt;

        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ifa.tx_done = 1'b0; ifa.tx_nack = 1'b0;
        ifb.tx_done = 1'b0; ifb.tx_nack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_tx_en", 32'(ifa.tx_en), 32'd0);
        check("rst_a_busy", 32'(busy_a), 32'd1);
        check("rst_a_init", 32'(init_a), 32'd0);
        check("rst_a_error", 32'(err_a), 32'd0);
        check("rst_a_err_index", 32'(eidx_a), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        check("rst_b_tx_en", 32'(ifb.tx_en), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Full sequence, all acked; entry 0 carries a 3-tick delay at PRESCALE=4.
        for (int i = 0; i < 10; i++) begin
            serve_a(1'b0, 1'b0, d, gap);
            check("t1_tx_data", 32'(d), 32'(exp_tbl[i]));
            if (i == 1) check("t1_delay_gap_12_to_14", 32'(gap >= 12 && gap <= 14), 32'd1);
            if (i == 2) check("t1_zero_delay_gap", 32'(gap <= 1), 32'd1);
        end
        check("t1_init_complete", 32'(init_a), 32'd1);
        check("t1_busy", 32'(busy_a), 32'd0);
        count_a_pulses(10, cnt);
        check("t1_no_pulse_in_done", 32'(cnt), 32'd0);
        check("t1_init_held", 32'(init_a), 32'd1);

        // Restart from DONE, NACK entry 3 twice, start poked while in WAIT.
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        check("t2_init_dropped", 32'(init_a), 32'd0);
        check("t2_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 12; i++) begin
            serve_a(t2_nack[i], (i == 1), d, gap);
            check("t2_tx_data", 32'(d), 32'(t2_data[i]));
        end
        check("t2_init_complete", 32'(init_a), 32'd1);
        check("t2_error", 32'(err_a), 32'd0);

        // Entry 5 NACKed four times exhausts MAX_RETRY=3.
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        for (int i = 0; i < 9; i++) begin
            serve_a(t3_nack[i], 1'b0, d, gap);
            check("t3_tx_data", 32'(d), 32'(t3_data[i]));
        end
        check("t3_error", 32'(err_a), 32'd1);
        check("t3_err_index", 32'(eidx_a), 32'd5);
        check("t3_init", 32'(init_a), 32'd0);
        check("t3_busy", 32'(busy_a), 32'd0);
        count_a_pulses(30, cnt);
        check("t3_no_pulse_in_error", 32'(cnt), 32'd0);
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        check("t3_error_cleared", 32'(err_a), 32'd0);
        serve_a(1'b0, 1'b0, d, gap);
        check("t3_restart_data", 32'(d), 32'hE2);

        // Instance B: idles until start, then async reset during WAIT of entry 6.
        count_b_pulses(10, cnt);
        check("b_idle_no_pulse", 32'(cnt), 32'd0);
        check("b_idle_busy", 32'(busy_b), 32'd0);
        start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            serve_b(1'b1, d);
            check("b_tx_data", 32'(d), 32'(exp_tbl[i]));
        end
        serve_b(1'b0, d);
        check("b_entry6_data", 32'(d), 32'h20);
        check("b_wait_busy", 32'(busy_b), 32'd1);
        #2 rst_b = 1'b1;
        #1;
        check("b_async_busy", 32'(busy_b), 32'd0);
        check("b_async_tx_en", 32'(ifb.tx_en), 32'd0);
        check("b_async_init", 32'(init_b), 32'd0);
        check("b_async_error", 32'(err_b), 32'd0);
        @(posedge clk); #1; rst_b = 1'b0;
        count_b_pulses(10, cnt);
        check("b_post_rst_no_pulse", 32'(cnt), 32'd0);
        check("b_post_rst_busy", 32'(busy_b), 32'd0);
        start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
        serve_b(1'b1, d);
        check("b_restart_data", 32'(d), 32'hE2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
